ntsc_timing_gen: RTL
====================

// Module: ntsc_timing_gen
// PURPOSE
//  Raster/sync timing generator directly upstream of the composite NTSC encoder that drives the 12-bit DAC pads.
//  - Runs at 4x colour subcarrier (14.318 MHz, 910 clk/line).
//  - Produces sync, blank, burst gate, subcarrier phase and pixel-request strobes.
//  - The encoder mixes these with pixel data into DAC codes.
//  - Default raster: 262-line progressive (240p).
// PARAMETERS
//  H_TOTAL       910  clocks per line
//  H_SYNC        67   hsync low width, clocks (4.7 us)
//  H_BURST_START 76   first burst-gate clock
//  H_BURST_LEN   36   burst-gate width (9 subcarrier cycles)
//  H_ACT_START   150  first active-pixel clock
//  H_ACTIVE      720  active pixels per line
//  V_TOTAL       262  lines per frame (progressive)
//  V_SYNC_START  3    first broad-pulse line
//  V_SYNC_LINES  3    broad-pulse line count
//  V_BURST_START 9    first line carrying burst
//  V_ACT_START   21   first active line
//  V_ACTIVE      240  active lines
//  PREFETCH      2    pix_req lead over active video, clocks (0..8)
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   synchronous reset, active-high
//  color_enable in   1   enable burst gate; sampled at line start
//  pix_req      out  1   request pixel x,y from upstream; one pixel per high cycle
//  x            out  10  pixel column being requested (0..H_ACTIVE-1)
//  y            out  9   active line index (0..V_ACTIVE-1)
//  sync_n       out  1   composite sync, low = sync tip
//  blank        out  1   high outside active video
//  burst        out  1   burst gate
//  phase        out  2   subcarrier phase, 0..3 (x90 deg)
//  line_start   out  1   1-cycle pulse at h==0
//  frame_start  out  1   1-cycle pulse at h==0, v==0
//  field        out  1   current field (interlace only, else 0)
// BEHAVIOUR
//  Counters and reset
//  - Internal h (0..H_TOTAL-1) and v (0..V_TOTAL-1) counters.
//  - h wraps to 0 and increments v; v wraps to 0 after V_TOTAL-1.
//  - All outputs registered; each reflects the h/v of the previous cycle (1-cycle latency).
//  - While rst is high: h=v=0, phase=0, sync_n=1, blank=1, all other outputs 0.
//  - First clock after release evaluates h=0,v=0 -> line_start=frame_start=1 next cycle.
//  - rst mid-line or mid-frame: same. Counters restart, no partial-line output.
//  Sync
//  - Normal line: sync_n=0 for h<H_SYNC.
//  - Lines V_SYNC_START..+V_SYNC_LINES-1 (broad pulses):
//    - sync_n=0 for h<H_TOTAL/2-H_SYNC;
//    - sync_n=0 for H_TOTAL/2<=h<H_TOTAL-H_SYNC;
//    - else 1.
//  Blanking and burst
//  - blank=0 only when v in [V_ACT_START, V_ACT_START+V_ACTIVE) and h in [H_ACT_START, H_ACT_START+H_ACTIVE).
//  - burst=1 when h in [H_BURST_START, +H_BURST_LEN), v>=V_BURST_START, and latched color_enable=1.
//  - color_enable latched at h==0; mid-line changes affect the next line only.
//  Subcarrier phase
//  - phase: free-running mod-4 counter, +1 every clock.
//  - H_TOTAL mod 4 = 2 gives the required 180-deg line-to-line inversion.
//  - Never reset by line/frame wrap.
//  Pixel request
//  - pix_req=1 on active lines for h in [H_ACT_START-PREFETCH, H_ACT_START+H_ACTIVE-PREFETCH).
//  - x = h-(H_ACT_START-PREFETCH) while pix_req=1, else held 0.
//  - y = v-V_ACT_START on active lines, else 0.
//  - Upstream must return pixel data exactly PREFETCH cycles later; no backpressure.
//  Boundary
//  - h wrap and v wrap in the same cycle: frame_start and line_start both pulse.
//  - pix_req never spans a line boundary.
// CONFIGURATION
//  NTSC_INTERLACE_EN
//  - Undefined: every frame V_TOTAL lines; field=0 always.
//  - Defined: fields alternate 263 lines (field 0) and 262 lines (field 1) = 525 lines/frame.
//    - field toggles at each v wrap.
//    - Field 1 broad-pulse region is shifted half a line late: starts at h=H_TOTAL/2 of line V_SYNC_START, ends at h=H_TOTAL/2 of line V_SYNC_START+V_SYNC_LINES.
//    - Active-line timing is identical in both fields.
//    - frame_start pulses at the start of each field.
// TESTING
//  1. rst held 5 clk then released -> all outputs at reset values during rst; first post-reset output cycle shows line_start=frame_start=1, sync_n=0.
//  2. Free-run 1 line (v=30) -> sync_n low exactly 67 clk; blank low for 720 clk starting at h=150; pix_req high from h=148 to 867, with x 0..719.
//  3. color_enable=1 -> burst high 36 clk from h=76 on v>=9, never on v<9. Toggle color_enable at h=400 -> burst changes only on the following line.
//  4. Lines 3..5 -> sync_n has two low pulses per line, of 388 clk each, at h=0 and h=455.
//  5. phase at h=0 alternates 0,2,0,2 on successive lines. Two full frames -> 524 line_starts, 2 frame_starts, y reaches 239 and wraps.
//  6. NTSC_INTERLACE_EN defined -> field 0 has 263 lines, field 1 has 262. Field-1 broad pulses begin at h=455 of line 3. rst asserted mid-field -> field=0, v=0.

Source files
------------

// File: rtl/ntsc_timing_gen_if.sv
// Sync/blank/burst/pixel-request bundle between the NTSC timing generator and the
// composite encoder. The generator drives everything except color_enable.
interface ntsc_timing_gen_if;
   logic       color_enable;
   logic       pix_req;
   logic [9:0] x;
   logic [8:0] y;
   logic       sync_n;
   logic       blank;
   logic       burst;
   logic [1:0] phase;
   logic       line_start;
   logic       frame_start;
   logic       field;

   modport master (
      input  color_enable,
      output pix_req, x, y, sync_n, blank, burst, phase, line_start, frame_start, field
   );

   modport slave (
      output color_enable,
      input  pix_req, x, y, sync_n, blank, burst, phase, line_start, frame_start, field
   );
endinterface

// File: rtl/ntsc_timing_gen.sv
// NTSC raster/sync timing generator at 4x fsc (910 clk/line), registered outputs.
// Define NTSC_INTERLACE_EN for 525-line interlace (263/262-line fields, field 1 sync shifted half a line).
module ntsc_timing_gen #(
   parameter int H_TOTAL       = 910,
   parameter int H_SYNC        = 67,
   parameter int H_BURST_START = 76,
   parameter int H_BURST_LEN   = 36,
   parameter int H_ACT_START   = 150,
   parameter int H_ACTIVE      = 720,
   parameter int V_TOTAL       = 262,
   parameter int V_SYNC_START  = 3,
   parameter int V_SYNC_LINES  = 3,
   parameter int V_BURST_START = 9,
   parameter int V_ACT_START   = 21,
   parameter int V_ACTIVE      = 240,
   parameter int PREFETCH      = 2
) (
   input  logic              clk,
   input  logic              rst,
   ntsc_timing_gen_if.master vid
);

`ifdef NTSC_INTERLACE_EN
   localparam bit INTERLACE = 1'b1;
`else
   localparam bit INTERLACE = 1'b0;
`endif

   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_HALF    = 10'(H_TOTAL / 2);
   localparam logic [9:0] H_SYNC_E  = 10'(H_SYNC);
   localparam logic [9:0] H_BROAD_A = 10'(H_TOTAL / 2 - H_SYNC);
   localparam logic [9:0] H_BROAD_B = 10'(H_TOTAL - H_SYNC);
   localparam logic [9:0] H_BU_S    = 10'(H_BURST_START);
   localparam logic [9:0] H_BU_E    = 10'(H_BURST_START + H_BURST_LEN);
   localparam logic [9:0] H_AC_S    = 10'(H_ACT_START);
   localparam logic [9:0] H_AC_E    = 10'(H_ACT_START + H_ACTIVE);
   localparam logic [9:0] H_PR_S    = 10'(H_ACT_START - PREFETCH);
   localparam logic [9:0] H_PR_E    = 10'(H_ACT_START + H_ACTIVE - PREFETCH);
   localparam logic [8:0] V_LAST    = 9'(V_TOTAL - 1);
   localparam logic [8:0] V_LAST_F0 = 9'(V_TOTAL);
   localparam logic [8:0] V_VS_S    = 9'(V_SYNC_START);
   localparam logic [8:0] V_VS_E    = 9'(V_SYNC_START + V_SYNC_LINES);
   localparam logic [8:0] V_BU_S    = 9'(V_BURST_START);
   localparam logic [8:0] V_AC_S    = 9'(V_ACT_START);
   localparam logic [8:0] V_AC_E    = 9'(V_ACT_START + V_ACTIVE);

   logic [9:0] h_q, h_d;
   logic [8:0] v_q, v_d;
   logic       field_q, field_d;
   logic       ce_q, ce_d;
   logic [1:0] ph_cnt_q, ph_cnt_d;
   logic [8:0] v_last;

   logic       sync_n_q, sync_n_d;
   logic       blank_q, blank_d;
   logic       burst_q, burst_d;
   logic       pix_req_q, pix_req_d;
   logic [9:0] x_q, x_d;
   logic [8:0] y_q, y_d;
   logic [1:0] phase_q, phase_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;
   logic       field_o_q, field_o_d;

   logic       act_line, second_half, in_broad, broad_lo;

   // Field 0 of an interlaced frame carries the extra half-line pair, hence one more line.
   assign v_last = (INTERLACE && !field_q) ? V_LAST_F0 : V_LAST;

   always_comb begin
      h_d      = h_q + 10'd1;
      v_d      = v_q;
      field_d  = field_q;
      ph_cnt_d = ph_cnt_q + 2'd1;
      ce_d     = (h_q == '0) ? vid.color_enable : ce_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         if (v_q == v_last) begin
            v_d     = '0;
            field_d = INTERLACE ? ~field_q : 1'b0;
         end else begin
            v_d = v_q + 9'd1;
         end
      end
   end

   always_comb begin
      act_line    = (v_q >= V_AC_S) && (v_q < V_AC_E);
      second_half = (h_q >= H_HALF);
      // Field 1 moves the broad-pulse window half a line later.
      if (INTERLACE && field_q)
         in_broad = ((v_q == V_VS_S) && second_half) ||
                    ((v_q > V_VS_S) && (v_q < V_VS_E)) ||
                    ((v_q == V_VS_E) && !second_half);
      else
         in_broad = (v_q >= V_VS_S) && (v_q < V_VS_E);
      broad_lo = second_half ? (h_q < H_BROAD_B) : (h_q < H_BROAD_A);

      sync_n_d      = in_broad ? !broad_lo : (h_q >= H_SYNC_E);
      blank_d       = !(act_line && (h_q >= H_AC_S) && (h_q < H_AC_E));
      burst_d       = ce_q && (v_q >= V_BU_S) && (h_q >= H_BU_S) && (h_q < H_BU_E);
      pix_req_d     = act_line && (h_q >= H_PR_S) && (h_q < H_PR_E);
      x_d           = pix_req_d ? (h_q - H_PR_S) : '0;
      y_d           = act_line ? (v_q - V_AC_S) : '0;
      phase_d       = ph_cnt_q;
      line_start_d  = (h_q == '0);
      frame_start_d = (h_q == '0) && (v_q == '0);
      field_o_d     = field_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_q           <= '0;
         v_q           <= '0;
         field_q       <= 1'b0;
         ce_q          <= 1'b0;
         ph_cnt_q      <= '0;
         sync_n_q      <= 1'b1;
         blank_q       <= 1'b1;
         burst_q       <= 1'b0;
         pix_req_q     <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         phase_q       <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         field_o_q     <= 1'b0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         field_q       <= field_d;
         ce_q          <= ce_d;
         ph_cnt_q      <= ph_cnt_d;
         sync_n_q      <= sync_n_d;
         blank_q       <= blank_d;
         burst_q       <= burst_d;
         pix_req_q     <= pix_req_d;
         x_q           <= x_d;
         y_q           <= y_d;
         phase_q       <= phase_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         field_o_q     <= field_o_d;
      end
   end

   assign vid.sync_n      = sync_n_q;
   assign vid.blank       = blank_q;
   assign vid.burst       = burst_q;
   assign vid.pix_req     = pix_req_q;
   assign vid.x           = x_q;
   assign vid.y           = y_q;
   assign vid.phase       = phase_q;
   assign vid.line_start  = line_start_q;
   assign vid.frame_start = frame_start_q;
   assign vid.field       = field_o_q;

endmodule
